// File: rtl/reset_controller.sv
// Classifies debounced reset-button presses: a short press yields a soft-reset
// pulse (deferred while the lock is busy), a long press raises a setup request.
module reset_controller #(
  parameter int LONG_CYCLES  = 3000,
  parameter int PULSE_LEN    = 4,
  parameter int BUSY_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_db,
  input  logic       lock_busy,
  input  logic       setup_ack,
  output logic       soft_rst,
  output logic       rst_forced,
  output logic       setup_req,
  output logic       hold_led,
  output logic [2:0] state_dbg
);

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int WW = $clog2(BUSY_TIMEOUT + 1);
  localparam int PW = $clog2(PULSE_LEN + 1);

  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] H_HALF = HW'(LONG_CYCLES / 2);
  localparam logic [WW-1:0] W_LAST = WW'(BUSY_TIMEOUT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_LEN - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD      = 3'd1,
    WAIT_BUSY = 3'd2,
    SOFT_RST  = 3'd3,
    SETUP_REQ = 3'd4,
    RELEASE   = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic          forced, forced_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hcnt   <= '0;
      wcnt   <= '0;
      pcnt   <= '0;
      forced <= 1'b0;
    end else begin
      state  <= state_nxt;
      hcnt   <= hcnt_nxt;
      wcnt   <= wcnt_nxt;
      pcnt   <= pcnt_nxt;
      forced <= forced_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hcnt_nxt   = hcnt;
    wcnt_nxt   = wcnt;
    pcnt_nxt   = pcnt;
    forced_nxt = forced;
    case (state)
      IDLE: begin
        hcnt_nxt = '0;
        if (rst_db) state_nxt = HOLD;
      end
      HOLD: begin
        // The sample that would push hcnt past LONG_CYCLES-1 makes the press long.
        if (rst_db) begin
          if (hcnt == H_LAST) state_nxt = SETUP_REQ;
          else                hcnt_nxt  = hcnt + HW'(1);
        end else if (lock_busy) begin
          state_nxt = WAIT_BUSY;
          wcnt_nxt  = '0;
        end else begin
          state_nxt  = SOFT_RST;
          pcnt_nxt   = '0;
          forced_nxt = 1'b0;
        end
      end
      WAIT_BUSY: begin
        if (!lock_busy) begin
          state_nxt  = SOFT_RST;
          pcnt_nxt   = '0;
          forced_nxt = 1'b0;
        end else if (wcnt == W_LAST) begin
          state_nxt  = SOFT_RST;
          pcnt_nxt   = '0;
          forced_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + WW'(1);
        end
      end
      SOFT_RST: begin
        if (pcnt == P_LAST) begin
          state_nxt  = IDLE;
          pcnt_nxt   = '0;
          forced_nxt = 1'b0;
        end else begin
          pcnt_nxt = pcnt + PW'(1);
        end
      end
      SETUP_REQ: if (setup_ack) state_nxt = RELEASE;
      RELEASE:   if (!rst_db)   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign soft_rst   = (state == SOFT_RST);
  assign rst_forced = (state == SOFT_RST) && forced && (pcnt == '0);
  assign setup_req  = (state == SETUP_REQ);
  assign hold_led   = ((state == HOLD) && (hcnt >= H_HALF)) ||
                      (state == SETUP_REQ) || (state == RELEASE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_reset_controller.sv
// Bench for reset_controller: a press-length based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_reset_controller;
  localparam int L = 20;
  localparam int P = 4;
  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_db = 1'b1;
  logic       lock_busy = 1'b1;
  logic       setup_ack = 1'b0;
  logic       soft_rst, rst_forced, setup_req, hold_led;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  reset_controller #(.LONG_CYCLES(L), .PULSE_LEN(P), .BUSY_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .rst_db(rst_db), .lock_busy(lock_busy),
    .setup_ack(setup_ack), .soft_rst(soft_rst), .rst_forced(rst_forced),
    .setup_req(setup_req), .hold_led(hold_led), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference: mode 0..5, held = number of rst_db=1 samples in this press,
  // waited = busy samples seen while deferred, pleft = pulse cycles remaining.
  int m_mode = 0, m_held = 0, m_wait = 0, m_pleft = 0;
  bit m_ff = 0, m_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_held <= 0; m_wait <= 0; m_pleft <= 0; m_ff <= 0; m_ok <= 1;
    end else if (m_ok) begin
      case (m_mode)
        0: if (rst_db) begin m_mode <= 1; m_held <= 1; end
        1: if (rst_db) begin
             if (m_held + 1 > L) m_mode <= 4;
             else m_held <= m_held + 1;
           end else if (lock_busy) begin
             m_mode <= 2; m_wait <= 0;
           end else begin
             m_mode <= 3; m_pleft <= P; m_ff <= 0;
           end
        2: if (!lock_busy) begin
             m_mode <= 3; m_pleft <= P; m_ff <= 0;
           end else if (m_wait + 1 == T) begin
             m_mode <= 3; m_pleft <= P; m_ff <= 1;
           end else m_wait <= m_wait + 1;
        3: begin
             m_ff <= 0;
             if (m_pleft == 1) m_mode <= 0;
             else m_pleft <= m_pleft - 1;
           end
        4: if (setup_ack) m_mode <= 5;
        5: if (!rst_db) m_mode <= 0;
        default: m_mode <= 0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        logic [6:0] exp_v, got_v;
        logic e_led;
        e_led = ((m_mode == 1) && (m_held - 1 >= L / 2)) || (m_mode == 4) || (m_mode == 5);
        exp_v = {3'(m_mode), (m_mode == 3), (m_mode == 3) && m_ff, (m_mode == 4), e_led};
        got_v = {state_dbg, soft_rst, rst_forced, setup_req, hold_led};
        n_cmp++;
        if (got_v !== exp_v) begin
          n_err++;
          $display("FAIL model t=%0t: got {st,soft,frc,req,led}=%b required %b", $time, got_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic db, input logic busy, input logic ack);
    rst_db = db; lock_busy = busy; setup_ack = ack;
    @(negedge clk);
  endtask

  task automatic settle();
    int k;
    k = 0;
    while (state_dbg != 3'd0 && k < 40) begin
      cyc(1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("settle_idle", state_dbg, 0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    // 1: reset dominates held button and busy lock
    @(negedge clk); @(negedge clk);
    chk("rst_outputs", {soft_rst, rst_forced, setup_req, hold_led}, 0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    chk("rst_then_hold", state_dbg, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_short_soft", soft_rst, 1);
    settle();

    // 2: short press, idle lock
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("short_soft_first", soft_rst, 1);
    chk("short_forced", rst_forced, 0);
    n = 1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (soft_rst) n++;
      if (setup_req) chk("short_no_req", setup_req, 0);
    end
    chk("short_pulse_len", n, 4);
    settle();

    // 3a: 20-cycle press is still short
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("h20_state", state_dbg, 1);
    chk("h20_req", setup_req, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("h20_soft", soft_rst, 1);
    settle();

    // 3b + 5: 21-cycle press is long; hold_led at hcnt=10; handshake
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("led_before", hold_led, 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("led_at_10", hold_led, 1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("h20_no_req", setup_req, 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("h21_req", setup_req, 1);
    chk("h21_state", state_dbg, 4);
    chk("h21_no_soft", soft_rst, 0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("req_held", setup_req, 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("ack_req_low", setup_req, 0);
    chk("ack_release", state_dbg, 5);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
    chk("release_held", state_dbg, 5);
    chk("release_no_req", setup_req, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("release_idle", state_dbg, 0);
    settle();

    // 4a: deferred, busy drops after 6 cycles
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("defer_wait", state_dbg, 2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("defer_still", soft_rst, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("defer_soft", soft_rst, 1);
    chk("defer_unforced", rst_forced, 0);
    settle();

    // 4b: busy stuck, forced after 10 wait cycles
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("timeout_wait9", state_dbg, 2);
    cyc(1'b0, 1'b1, 1'b0);
    chk("timeout_soft", soft_rst, 1);
    chk("timeout_forced", rst_forced, 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("timeout_forced_once", rst_forced, 0);
    chk("timeout_soft2", soft_rst, 1);
    settle();

    // 6a: abort mid-pulse
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_pulse2", soft_rst, 1);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_soft", soft_rst, 0);
    chk("abort_state", state_dbg, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_stays_idle", state_dbg, 0);

    // 6b: abort with setup_req high
    for (int i = 0; i < 21; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("abort_req_up", setup_req, 1);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("abort_req", setup_req, 0);
    chk("abort_req_state", state_dbg, 0);
    chk("abort_led", hold_led, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_req_idle", state_dbg, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/reset_controller.md
Name: reset_controller

Overview:
Sequences the lock's user reset button after the debouncer. It consumes the debounced level `rst_db` and classifies each press as short or long. A short press (≤ LONG_CYCLES) issues a fixed-width soft-reset pulse to the lock FSM, deferred while the lock is mid-operation. A long press raises a setup-mode request (password change) with a req/ack handshake. It sits between the reset debouncer and the main lock FSM.

Parameters:
LONG_CYCLES, 3000, held cycles above which a press is long (≥2)
PULSE_LEN, 4, width in cycles of the soft_rst pulse (≥1)
BUSY_TIMEOUT, 1000, max cycles a short-press reset waits on lock_busy before forcing (≥1)

Ports:
clk  in  1  system clock
rst  in  1  system reset; synchronous, active-high
rst_db  in  1  debounced reset-button level (high = held)
lock_busy  in  1  lock FSM mid-operation; defers soft reset
setup_ack  in  1  lock FSM accepted setup-mode request
soft_rst  out  1  soft-reset pulse to lock FSM, PULSE_LEN cycles
rst_forced  out  1  one-cycle flag: this soft_rst was forced by timeout
setup_req  out  1  setup-mode request, held until acknowledged
hold_led  out  1  user feedback: long press approaching or active
state_dbg  out  3  current state encoding, for debug

Behaviour:
- States (state_dbg encoding): IDLE=0, HOLD=1, WAIT_BUSY=2, SOFT_RST=3, SETUP_REQ=4, RELEASE=5. Only these are reachable.
- rst=1 takes priority over everything.
  - Next state is IDLE; hold counter, wait counter, pulse counter and forced flag all clear.
  - All outputs read 0, with state_dbg=0, in the cycle after rst is sampled.
- Outputs are Moore decodes of registered state and counters. No input-to-output combinational path.
  - soft_rst=1 iff state==SOFT_RST.
  - setup_req=1 iff state==SETUP_REQ.
  - rst_forced=1 only in the first SOFT_RST cycle when entry was from a WAIT_BUSY timeout.
  - hold_led=1 in HOLD when hcnt ≥ LONG_CYCLES/2 (integer divide), and in SETUP_REQ and RELEASE.
- IDLE: hcnt=0. If rst_db=1, go to HOLD. IDLE is level-sensitive, so a button still held on return to IDLE starts a new press.
- HOLD: each cycle with rst_db=1, hcnt increments.
  - If rst_db=1 and hcnt==LONG_CYCLES-1, go to SETUP_REQ. Entry does not wait for release.
  - If rst_db=0 (short press) and lock_busy=0, go to SOFT_RST.
  - If rst_db=0 (short press) and lock_busy=1, go to WAIT_BUSY with wcnt=0.
  - lock_busy is sampled in the same cycle rst_db=0 is seen.
- Press-length boundary. Let H be the number of consecutive cycles rst_db=1 is sampled, starting in IDLE.
  - H ≤ LONG_CYCLES is short.
  - H ≥ LONG_CYCLES+1 is long.
  - setup_req rises LONG_CYCLES+1 cycles after the first rst_db=1 sample.
- WAIT_BUSY:
  - lock_busy=0: go to SOFT_RST (not forced).
  - Else if wcnt==BUSY_TIMEOUT-1: go to SOFT_RST with forced flag set.
  - Else wcnt++.
  - rst_db is ignored in this state.
- SOFT_RST: stay exactly PULSE_LEN cycles, then go to IDLE. rst_db and lock_busy are ignored. The forced flag clears on exit.
- SETUP_REQ:
  - Hold setup_req until setup_ack=1 is sampled, then go to RELEASE. setup_req reads 0 in the next cycle.
  - No timeout.
  - setup_ack outside SETUP_REQ is ignored.
- RELEASE: wait for rst_db=0, then go to IDLE. This guarantees one long press produces exactly one setup request.
- Counters are sized $clog2(param+1) and never wrap. hcnt cannot exceed LONG_CYCLES-1 in HOLD.
- rst asserted mid-operation (any state, including mid-pulse or with setup_req high) aborts immediately. No pulse completion and no pending request survive.

Test Plan:
(Bench params: LONG_CYCLES=20, PULSE_LEN=4, BUSY_TIMEOUT=10.)
1. Reset: rst=1 for 2 cycles with rst_db=1 and lock_busy=1 → all outputs 0 and state_dbg=0. After release, HOLD is entered 1 cycle later.
2. Short press, idle lock: rst_db=1 for 5 cycles, lock_busy=0 → soft_rst high exactly 4 cycles starting 1 cycle after the first rst_db=0 sample; rst_forced=0; setup_req never rises.
3. Length boundary:
   - rst_db held 20 cycles → soft_rst pulse, no setup_req.
   - rst_db held 21 cycles → setup_req rises 21 cycles after the first rst_db=1; no soft_rst.
   - hold_led rises when hcnt reaches 10.
4. Deferred reset: short press with lock_busy=1, lock_busy drops 6 cycles later → soft_rst starts the cycle after the drop, rst_forced=0. Repeat with lock_busy stuck high → soft_rst starts after 10 WAIT_BUSY cycles and rst_forced=1 for exactly 1 cycle.
5. Setup handshake: long press, setup_ack pulsed 7 cycles after setup_req rises, button still held → setup_req falls the next cycle and state is RELEASE. No new request until rst_db=0, then IDLE.
6. Abort: rst asserted in the 2nd soft_rst cycle → soft_rst=0 the next cycle and state IDLE. Same check with setup_req high.
